// File: rtl/drive_cmd_uart_tx_if.sv
// ---------------------------------------------------------------------------
// drive_cmd_uart_tx_if
// Signal bundle between the drive-request source and the command transmitter.
//   enable      : 1 = drive requests honoured, 0 = command forced to stop
//   req_fwd/back/left/right : raw direction requests
//   tx          : UART serial line, idle high
//   busy        : high while a frame (start..stop bit) is on the line
//   frame_done  : one-cycle pulse on the last cycle of the stop bit
//   last_cmd    : command byte of the most recently started frame
// master = request source (bench / nav logic), slave = transmitter.
// ---------------------------------------------------------------------------
interface drive_cmd_uart_tx_if;
  logic       enable;
  logic       req_fwd;
  logic       req_back;
  logic       req_left;
  logic       req_right;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] last_cmd;

  modport master (
    output enable, req_fwd, req_back, req_left, req_right,
    input  tx, busy, frame_done, last_cmd
  );

  modport slave (
    input  enable, req_fwd, req_back, req_left, req_right,
    output tx, busy, frame_done, last_cmd
  );
endinterface

// File: rtl/drive_cmd_uart_tx.sv
// ---------------------------------------------------------------------------
// drive_cmd_uart_tx
// Encodes direction requests into the car's command byte and sends it over a
// UART 8N1 line whenever the command changes, and as a heartbeat after
// HEARTBEAT_CYCLES-1 cycles without a frame start.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : drive_cmd_uart_tx_if.slave (requests in; tx/busy/frame_done/last_cmd out)
// Parameters:
//   CLKS_PER_BIT     : clock cycles per UART bit (>= 2)
//   HEARTBEAT_CYCLES : heartbeat period in cycles (>= 10*CLKS_PER_BIT)
// ---------------------------------------------------------------------------
module drive_cmd_uart_tx #(
  parameter int CLKS_PER_BIT     = 434,
  parameter int HEARTBEAT_CYCLES = 5000000
) (
  input logic                clk,
  input logic                rst_n,
  drive_cmd_uart_tx_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int HB_W   = $clog2(HEARTBEAT_CYCLES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_q;
  logic [7:0]        last_q;
  logic [HB_W-1:0]   hb_cnt;

  logic [7:0] cmd;
  logic       f, b, l, r;
  logic       baud_last;
  logic       hb_max;
  logic       trigger;
  logic       tx_c, busy_c, frame_done_c;

  // Opposite requests cancel each other, so 0x0A-style codes cannot occur.
  // NOTE: every always_comb output gets a value on every path (here trivially,
  // elsewhere via defaults at the top) so no latch is inferred.
  always_comb begin
    f   = bus.req_fwd   & ~bus.req_back;
    b   = bus.req_back  & ~bus.req_fwd;
    l   = bus.req_left  & ~bus.req_right;
    r   = bus.req_right & ~bus.req_left;
    cmd = bus.enable ? {4'b0000, r, b, l, f} : 8'h00;
  end

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign hb_max    = (hb_cnt == HB_W'(HEARTBEAT_CYCLES - 1));
  assign trigger   = (cmd != last_q) || hb_max;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trigger)                     state_d = START;
      START:   if (baud_last)                   state_d = DATA;
      DATA:    if (baud_last && bit_idx == 3'd7) state_d = STOP;
      STOP:    if (baud_last)                   state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // Outputs decode from the state register only, so asserting rst_n pulls
  // tx high and busy low immediately, without waiting for a clock.
  always_comb begin
    tx_c         = 1'b1;
    busy_c       = 1'b0;
    frame_done_c = 1'b0;
    unique case (state_q)
      START: begin tx_c = 1'b0;             busy_c = 1'b1; end
      DATA:  begin tx_c = shift_q[bit_idx]; busy_c = 1'b1; end
      STOP:  begin busy_c = 1'b1; frame_done_c = baud_last; end
      default: ;
    endcase
  end

  // Datapath: baud/bit counters, latched frame byte, heartbeat timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      last_q   <= '0;
      hb_cnt   <= '0;
    end else begin
      if (!hb_max) hb_cnt <= hb_cnt + HB_W'(1);

      if (state_q == IDLE || baud_last) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + BAUD_W'(1);

      if (state_q == START)                   bit_idx <= '0;
      else if (state_q == DATA && baud_last)  bit_idx <= bit_idx + 3'd1;

      // The byte is frozen here; request changes mid-frame cannot reach tx.
      // The hb_cnt clear overrides the increment above (last assignment wins).
      if (state_q == IDLE && trigger) begin
        shift_q <= cmd;
        last_q  <= cmd;
        hb_cnt  <= '0;
      end
    end
  end

  assign bus.tx         = tx_c;
  assign bus.busy       = busy_c;
  assign bus.frame_done = frame_done_c;
  assign bus.last_cmd   = last_q;

endmodule
